loading_bar_updater: RTL

//  AXI4-Lite write-only master that drives the loading-bar peripheral's register file from the miner.
//  - Start: enables the bar.
//  - Run: tracks nonce progress and rewrites LEVEL when the lit-LED count changes, rate-limited.
//  - Done: forces a full bar.

---
 rtl/loading_bar_pkg.sv | 18 +
 rtl/loading_bar_level_tracker.sv | 44 ++++
 rtl/loading_bar_updater.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/loading_bar_pkg.sv
// Shared definitions for the loading-bar AXI4-Lite updater: register map,
// response encoding and the write-sequencer state type.
package loading_bar_pkg;

   localparam logic [31:0] CTRL_OFS    = 32'h0;
   localparam logic [31:0] LEVEL_OFS   = 32'h4;
   localparam int          CTRL_EN_BIT = 0;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;

   typedef enum logic [2:0] {
      IDLE,
      WR_CTRL,
      RUN,
      WR_LVL,
      WR_FINAL
   } state_t;

endpackage

// File: rtl/loading_bar_level_tracker.sv
// Converts miner progress into a lit-LED count without a divider: the next
// threshold (level+1)*total is kept as a running sum and compared to progress*NUM_LEDS.
module loading_bar_level_tracker #(
   parameter int NUM_LEDS   = 8,
   parameter int PROG_WIDTH = 32,
   localparam int LW        = $clog2(NUM_LEDS + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  track,
   input  logic [PROG_WIDTH-1:0] total,
   input  logic [PROG_WIDTH-1:0] progress,
   output logic [LW-1:0]         level,
   output logic                  full
);

   localparam int              SW         = PROG_WIDTH + LW;
   localparam logic [LW-1:0]   FULL_LEVEL = LW'(NUM_LEDS);

   logic [PROG_WIDTH-1:0] total_q;
   logic [SW-1:0]         thr;
   logic [SW-1:0]         scaled;

   assign scaled = SW'(progress) * SW'(NUM_LEDS);
   assign full   = (level == FULL_LEVEL);

   // An empty job is complete by definition, so it jumps straight to a full bar.
   always_ff @(posedge clk) begin
      if (reset) begin
         level   <= '0;
         thr     <= '0;
         total_q <= '0;
      end else if (clear) begin
         total_q <= total;
         thr     <= SW'(total);
         level   <= (total == '0) ? FULL_LEVEL : '0;
      end else if (track && !full && (scaled >= thr)) begin
         level <= level + 1'b1;
         thr   <= thr + SW'(total_q);
      end
   end

endmodule

// File: rtl/loading_bar_updater.sv
// AXI4-Lite write-only master that enables the loading bar on start, rewrites
// LEVEL as the miner progresses (rate-limited) and forces a full bar on done.
module loading_bar_updater
   import loading_bar_pkg::*;
#(
   parameter int          C_M_AXI_ADDR_WIDTH = 32,
   parameter int          C_M_AXI_DATA_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR          = 32'h0,
   parameter int          NUM_LEDS           = 8,
   parameter int          PROG_WIDTH         = 32,
   parameter int          MIN_GAP            = 1024
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic                            start,
   input  logic [PROG_WIDTH-1:0]           total,
   input  logic [PROG_WIDTH-1:0]           progress,
   input  logic                            done,
   output logic                            busy,
   output logic                            err,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]                      m_axi_awprot,
   output logic                            m_axi_awvalid,
   input  logic                            m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                            m_axi_wvalid,
   input  logic                            m_axi_wready,
   input  logic [1:0]                      m_axi_bresp,
   input  logic                            m_axi_bvalid,
   output logic                            m_axi_bready
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int LW = $clog2(NUM_LEDS + 1);
   localparam int GW = $clog2(MIN_GAP + 1);

   localparam logic [31:0]   CTRL_ADDR32  = BASE_ADDR + CTRL_OFS;
   localparam logic [31:0]   LEVEL_ADDR32 = BASE_ADDR + LEVEL_OFS;
   localparam logic [AW-1:0] CTRL_ADDR    = AW'(CTRL_ADDR32);
   localparam logic [AW-1:0] LEVEL_ADDR   = AW'(LEVEL_ADDR32);
   localparam logic [DW-1:0] CTRL_WORD    = DW'(1) << CTRL_EN_BIT;
   localparam logic [DW-1:0] FULL_WORD    = DW'(NUM_LEDS);
   localparam logic [GW-1:0] GAP_RELOAD   = GW'(MIN_GAP);

   state_t          state, state_n;
   logic            awvalid_n, wvalid_n, bready_n;
   logic [AW-1:0]   awaddr_n;
   logic [DW-1:0]   wdata_n;
   logic [LW-1:0]   sent, sent_n;
   logic [GW-1:0]   gap, gap_n;
   logic            done_pend, done_pend_n;
   logic            err_n;
   logic            clear;
   logic [LW-1:0]   level;
   logic            level_full;
   logic            in_write, aw_ok, w_ok, b_done;

   assign m_axi_awprot = 3'b000;
   assign m_axi_wstrb  = '1;
   assign busy         = (state != IDLE);

   loading_bar_level_tracker #(
      .NUM_LEDS   (NUM_LEDS),
      .PROG_WIDTH (PROG_WIDTH)
   ) u_tracker (
      .clk      (ACLK),
      .reset    (ARESET),
      .clear    (clear),
      .track    (busy && !level_full),
      .total    (total),
      .progress (progress),
      .level    (level),
      .full     (level_full)
   );

   assign in_write = (state == WR_CTRL) || (state == WR_LVL) || (state == WR_FINAL);
   assign aw_ok    = !m_axi_awvalid || m_axi_awready;
   assign w_ok     = !m_axi_wvalid || m_axi_wready;
   assign b_done   = m_axi_bvalid && m_axi_bready;

   // Each write is launched on the edge that enters its state; the write
   // states only wait for the channels to drain and for B to come back.
   always_comb begin
      state_n     = state;
      awvalid_n   = m_axi_awvalid && !m_axi_awready;
      wvalid_n    = m_axi_wvalid && !m_axi_wready;
      bready_n    = m_axi_bready ? !m_axi_bvalid : (in_write && aw_ok && w_ok);
      awaddr_n    = m_axi_awaddr;
      wdata_n     = m_axi_wdata;
      sent_n      = sent;
      done_pend_n = done_pend;
      gap_n       = (gap != '0) ? gap - 1'b1 : gap;
      err_n       = err || (b_done && (m_axi_bresp != RESP_OKAY));
      clear       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clear       = 1'b1;
               err_n       = 1'b0;
               sent_n      = '0;
               done_pend_n = 1'b0;
               awvalid_n   = 1'b1;
               wvalid_n    = 1'b1;
               awaddr_n    = CTRL_ADDR;
               wdata_n     = CTRL_WORD;
               state_n     = WR_CTRL;
            end
         end
         WR_CTRL: begin
            if (done)   done_pend_n = 1'b1;
            if (b_done) state_n     = RUN;
         end
         RUN: begin
            if (done_pend || done) begin
               done_pend_n = 1'b0;
               awvalid_n   = 1'b1;
               wvalid_n    = 1'b1;
               awaddr_n    = LEVEL_ADDR;
               wdata_n     = FULL_WORD;
               state_n     = WR_FINAL;
            end else if ((level != sent) && (gap == '0)) begin
               sent_n    = level;
               awvalid_n = 1'b1;
               wvalid_n  = 1'b1;
               awaddr_n  = LEVEL_ADDR;
               wdata_n   = DW'(level);
               state_n   = WR_LVL;
            end
         end
         WR_LVL: begin
            if (done) done_pend_n = 1'b1;
            if (b_done) begin
               gap_n   = GAP_RELOAD;
               state_n = RUN;
            end
         end
         WR_FINAL: begin
            if (b_done) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state         <= IDLE;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_wdata   <= '0;
         sent          <= '0;
         gap           <= '0;
         done_pend     <= 1'b0;
         err           <= 1'b0;
      end else begin
         state         <= state_n;
         m_axi_awvalid <= awvalid_n;
         m_axi_wvalid  <= wvalid_n;
         m_axi_bready  <= bready_n;
         m_axi_awaddr  <= awaddr_n;
         m_axi_wdata   <= wdata_n;
         sent          <= sent_n;
         gap           <= gap_n;
         done_pend     <= done_pend_n;
         err           <= err_n;
      end
   end

endmodule
